// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory block.
package dmem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } dmem_state_e;

  // Misaligned or beyond the last stored word.
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || (32'(addr[ADDR_W-1:2]) >= depth);
  endfunction

endpackage

// File: rtl/data_mem_if.sv
// Load/store request and response channels between execute stage and data memory.
// Optional byte strobes are present when DMEM_BYTE_STROBE_EN is defined.
interface data_mem_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
  logic [STRB_W-1:0] req_strb;
`endif
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

`ifdef DMEM_BYTE_STROBE_EN
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_strb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_strb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
`else
  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
`endif

endinterface

// File: rtl/dmem_array.sv
// Synchronous single-port word array with per-byte write enables and registered read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IdxW  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic [STRB_W-1:0] be_i,
  input  logic [IdxW-1:0]   idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Contents are deliberately never reset.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (be_i[i]) begin
          mem[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
      rdata_q <= mem[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem.sv
// Latency-configurable data memory: IDLE -> WAIT -> RESP handshake around dmem_array.
// Define DMEM_BYTE_STROBE_EN to enable per-byte store strobes.
module data_mem
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input logic       clk,
  input logic       rst,
  data_mem_if.slave bus
);

  localparam int unsigned IdxW    = $clog2(DEPTH);
  localparam bit          ZeroLat = (LATENCY == 0);
  localparam logic [3:0]  CntInit = ZeroLat ? 4'd0 : 4'(LATENCY - 1);

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        init_q;
  logic        accept, commit;

  logic              we_q, err_q;
  logic [IdxW-1:0]   idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] strb_q;

  logic              req_err;
  logic [STRB_W-1:0] req_strb;

  logic              acc_we, acc_err;
  logic [IdxW-1:0]   acc_idx;
  logic [DATA_W-1:0] acc_wdata;
  logic [STRB_W-1:0] acc_strb;
  logic [STRB_W-1:0] arr_be;
  logic [DATA_W-1:0] arr_rdata;

`ifdef DMEM_BYTE_STROBE_EN
  assign req_strb = bus.req_strb;
`else
  assign req_strb = '1;
`endif

  assign req_err       = addr_err(bus.req_addr, DEPTH);
  assign bus.req_ready = init_q && (state_q == StIdle);
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (ZeroLat) begin
            state_d = StResp;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (bus.resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // init_q keeps req_ready low until the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      init_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      err_q   <= req_err;
      idx_q   <= bus.req_addr[IdxW+1:2];
      wdata_q <= bus.req_wdata;
      strb_q  <= req_strb;
    end
  end

  // With zero latency the commit happens on the accepting edge, so use live request fields.
  always_comb begin
    acc_we    = we_q;
    acc_err   = err_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    acc_strb  = strb_q;
    if (state_q == StIdle) begin
      acc_we    = bus.req_we;
      acc_err   = req_err;
      acc_idx   = bus.req_addr[IdxW+1:2];
      acc_wdata = bus.req_wdata;
      acc_strb  = req_strb;
    end
  end

  assign arr_be = (commit && acc_we && !acc_err) ? acc_strb : '0;

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i   (clk),
    .en_i    (commit),
    .be_i    (arr_be),
    .idx_i   (acc_idx),
    .wdata_i (acc_wdata),
    .rdata_o (arr_rdata)
  );

  assign bus.resp_valid = (state_q == StResp);
  assign bus.resp_err   = bus.resp_valid && err_q;
  assign bus.resp_rdata = (bus.resp_valid && !we_q && !err_q) ? arr_rdata : '0;

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit words stored; a power of two.
REQ-002 Parameter LATENCY, default 2: wait cycles between request acceptance and response; legal range 0..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req_valid  input  1  load/store request present from the execute stage.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_we  input  1  1 = store (sw), 0 = load (lw).
REQ-008 req_addr  input  32  byte address, i.e. the ALU result oprend1 + sext(offset).
REQ-009 req_wdata  input  32  store data.
REQ-010 resp_valid  output  1  response present.
REQ-011 resp_ready  input  1  consumer accepts the response.
REQ-012 resp_rdata  output  32  load data; 0 for stores and for errors.
REQ-013 resp_err  output  1  request was misaligned or out of range.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-015 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid && req_ready, and its we/addr/wdata (and strobe) are registered at acceptance.
REQ-016 On acceptance the FSM SHALL go IDLE->WAIT with the wait counter loaded to LATENCY-1, or IDLE->RESP directly when LATENCY=0.
REQ-017 In WAIT the counter SHALL decrement once per cycle; at 0 the FSM SHALL go WAIT->RESP.
REQ-018 Commit point: on entry to RESP the array SHALL be read, or written for stores, exactly once; load data SHALL be registered into resp_rdata.
REQ-019 resp_valid SHALL be 1 throughout RESP; resp_rdata and resp_err SHALL be held stable until resp_valid && resp_ready.
REQ-020 On resp_valid && resp_ready the FSM SHALL go RESP->IDLE; a new request is not accepted in that same cycle, giving a minimum occupancy of LATENCY+2 cycles per request.
REQ-021 Error: if addr[1:0]!=0 or addr[31:2]>=DEPTH, then resp_err=1, resp_rdata=0 and no write occurs; the timing is identical to a normal access.
REQ-022 Word index SHALL be addr[log2(DEPTH)+1:2]; upper address bits SHALL take part only in the range check.
REQ-023 req_valid asserted outside IDLE SHALL be ignored and not queued.

Reset
REQ-024 Asserting rst SHALL force state=IDLE, counter=0, resp_valid=0, resp_rdata=0 and resp_err=0 immediately; req_ready SHALL become 1 on the first clock edge after rst deasserts.
REQ-025 Reset during WAIT SHALL drop the pending request, and a pending store SHALL NOT write.
REQ-026 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-027 With macro DMEM_BYTE_STROBE_EN defined: input req_strb[3:0] SHALL be added; a store writes byte i only where req_strb[i]=1; req_strb=0 SHALL still complete as a store with no write.
REQ-028 Without DMEM_BYTE_STROBE_EN: req_strb SHALL be absent and every store SHALL write all 4 bytes.

Structure
REQ-029 Package dmem_pkg SHALL hold the state enum (IDLE/WAIT/RESP), DATA_W=32, ADDR_W=32 and the strobe width constant.
REQ-030 The storage SHALL be sub-module dmem_array: synchronous single-port, with per-byte write enable and registered read.

Verification
REQ-031 Store addr=0x10, wdata=0xDEADBEEF, then load addr=0x10 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid rising 3 cycles after acceptance (LATENCY=2).
REQ-032 Load addr=0x12 -> resp_err=1, resp_rdata=0; load addr=0x400 with DEPTH=256 -> resp_err=1; a store to 0x400 leaves all words unchanged.
REQ-033 Hold resp_ready=0 for 5 cycles -> resp_valid, resp_rdata and resp_err stay stable and req_ready=0; a req_valid pulse in this window is never serviced.
REQ-034 Store 0x11223344 to 0x20, assert rst during WAIT, then load 0x20 -> old value returned; resp_valid=0 immediately on rst.
REQ-035 With DMEM_BYTE_STROBE_EN defined: word 0x8 = 0xAABBCCDD, store 0x00000011 with strb=4'b0001 -> load returns 0xAABBCC11; LATENCY=0 gives resp_valid one cycle after acceptance.
